fifo_wr_ctrl: RTL

Write-side pointer controller for the dual-clock FIFO. It runs entirely in the write clock domain and owns the write binary pointer, its Gray-coded copy for export, and the memory write strobe and address. It brings the read domain's Gray pointer in through a two-flop synchronizer, decodes it to binary, and derives fill level, full, almost-full and a sticky overflow flag. The read-side controller and the RAM sit beside it; the only crossing signal is the Gray pointer pair.

---
 rtl/fifo_wr_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO (write clock domain only).
// Latency: wr_en_o same cycle as wrreq_i; pointer/Gray/usedw/flags update at next edge; read pointer seen 3 edges later.
// Backpressure: requests are dropped while full_o is high and latch the sticky ovf_o flag.
module fifo_wr_ctrl #(
  parameter int AWIDTH    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wrreq_i,
  input  logic              ovf_clr_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic              wr_en_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              ovf_o
);

  localparam logic [AWIDTH:0] DEPTH     = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AFULL_THR = AFULL_LVL[AWIDTH:0];

  logic [AWIDTH:0] wr_bin;
  logic [AWIDTH:0] wr_bin_next;
  logic [AWIDTH:0] rd_s1;
  logic [AWIDTH:0] rd_s2;
  logic [AWIDTH:0] rd_bin;
  logic [AWIDTH:0] fill_next;

  // Strobe is combinational so the producer gets a zero-cycle accept;
  // full_o is registered, so there is no loop through the flag logic.
  assign wr_en_o     = wrreq_i & ~full_o;
  assign wr_addr_o   = wr_bin[AWIDTH-1:0];
  assign wr_bin_next = wr_bin + {{AWIDTH{1'b0}}, wr_en_o};

  // Decode the synchronized Gray pointer: each bit is the XOR of itself and all higher bits
  always_comb begin
    rd_bin = '0;
    for (int k = 0; k <= AWIDTH; k++) begin
      rd_bin[k] = ^(rd_s2 >> k);
    end
  end

  // Modular difference stays correct when either pointer wraps
  assign fill_next = wr_bin_next - rd_bin;

  // Advance the binary pointer and its registered Gray copy together
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bin         <= '0;
      wr_pntr_gray_o <= '0;
    end else begin
      wr_bin         <= wr_bin_next;
      wr_pntr_gray_o <= wr_bin_next ^ (wr_bin_next >> 1);
    end
  end

  // Two-flop synchronizer; nothing sits between the async input and the first flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_s1 <= '0;
      rd_s2 <= '0;
    end else begin
      rd_s1 <= rd_pntr_gray_i;
      rd_s2 <= rd_s1;
    end
  end

  // Fill level and flags follow the post-write pointer so full rises on the filling write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      usedw_o       <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
    end else begin
      usedw_o       <= fill_next;
      full_o        <= (fill_next == DEPTH);
      almost_full_o <= (fill_next >= AFULL_THR);
    end
  end

  // Sticky overflow: a dropped write sets it, and set beats a simultaneous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (wrreq_i && full_o) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule
